cu_eeprom_rdbuff: RTL and testbench

// - Read-side control unit for the SPI EEPROM/flash logger store; counterpart of the page-program writer.
// - Issues READ (cmd + 24-bit address), clocks in PAGE_BYTES data bytes per page and writes them into a page buffer.
// - Reads consecutive pages until data_done; sits between the SPI byte engine and the readback/upload buffer.

---
 rtl/cu_eeprom_rdbuff.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_cu_eeprom_rdbuff.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_eeprom_rdbuff.sv
// cu_eeprom_rdbuff
// Read-side control unit for the SPI EEPROM/flash logger store. Issues a
// READ command (opcode + 24-bit address), clocks in PAGE_BYTES data bytes per
// page into a page buffer, and continues page by page until data_done.
//
// Optional feature macro: EEPROM_RD_WIP_POLL_EN
//   When defined, every page read is preceded by an RDSR status poll that
//   repeats until the WIP bit (spi_rx_data[0]) reads 0.
//
// Ports
//   clk, reset          clock; asynchronous active-high reset
//   start_pulse         1-cycle start, ignored while busy
//   start_addr[23:0]    first page byte address, latched on accepted start
//   data_done           stop after current page (sampled in CHK_DONE/WAIT_BUF)
//   buf_free            consumer drained buffer, next page allowed
//   spi_done            1-cycle pulse, SPI exchange finished, spi_rx_data valid
//   spi_rx_data[7:0]    byte received in the last exchange
//   spi_load            1-cycle pulse, start exchange of spi_tx_data
//   spi_tx_data[7:0]    byte to transmit
//   nCS                 EEPROM chip select, active low
//   buf_we              1-cycle buffer write strobe
//   buf_addr[7:0]       buffer byte index
//   buf_wdata[7:0]      buffer write data
//   page_done           1-cycle pulse, page complete in buffer
//   busy                high from accepted start until return to IDLE
module cu_eeprom_rdbuff #(
  parameter int unsigned PAGE_BYTES = 256,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter logic [7:0]  RDSR_CMD   = 8'h05,
  parameter int unsigned CS_GAP     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_pulse,
  input  logic [23:0] start_addr,
  input  logic        data_done,
  input  logic        buf_free,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx_data,
  output logic        spi_load,
  output logic [7:0]  spi_tx_data,
  output logic        nCS,
  output logic        buf_we,
  output logic [7:0]  buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        page_done,
  output logic        busy
);

  localparam logic [7:0]  BYTE_LAST = 8'(PAGE_BYTES - 1);
  localparam logic [7:0]  GAP_LAST  = 8'(CS_GAP - 1);
  localparam logic [23:0] PAGE_INC  = 24'(PAGE_BYTES);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CS_LOW,
    ST_HDR_LD,
    ST_HDR_WT,
    ST_DAT_LD,
    ST_DAT_WT,
    ST_PAGE_END,
    ST_CS_GAP,
    ST_CHK_DONE,
    ST_WAIT_BUF
`ifdef EEPROM_RD_WIP_POLL_EN
    , ST_POLL_CS,
    ST_POLL_LD,
    ST_POLL_WT,
    ST_POLL_GAP
`endif
  } state_t;

  // First state of every page transaction.
`ifdef EEPROM_RD_WIP_POLL_EN
  localparam state_t PAGE_ENTRY = ST_POLL_CS;
`else
  localparam state_t PAGE_ENTRY = ST_CS_LOW;
`endif

  state_t      state_q, state_d;
  logic [23:0] cur_addr_q, cur_addr_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        ncs_q, ncs_d;
  logic        spi_load_q, spi_load_d;
  logic [7:0]  spi_tx_data_q, spi_tx_data_d;
  logic        buf_we_q, buf_we_d;
  logic [7:0]  buf_addr_q, buf_addr_d;
  logic [7:0]  buf_wdata_q, buf_wdata_d;
  logic        page_done_q, page_done_d;
  logic        busy_q, busy_d;
`ifdef EEPROM_RD_WIP_POLL_EN
  logic        wip_q, wip_d;
`endif

  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [23:0] a);
    case (idx)
      2'd0:    hdr_byte = READ_CMD;
      2'd1:    hdr_byte = a[23:16];
      2'd2:    hdr_byte = a[15:8];
      default: hdr_byte = a[7:0];
    endcase
  endfunction

  // Registered outputs are computed on the transition into a state, so each
  // output value lines up with the state that owns it.
  always_comb begin
    state_d       = state_q;
    cur_addr_d    = cur_addr_q;
    hdr_cnt_d     = hdr_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    ncs_d         = ncs_q;
    spi_load_d    = 1'b0;
    spi_tx_data_d = spi_tx_data_q;
    buf_we_d      = 1'b0;
    buf_addr_d    = buf_addr_q;
    buf_wdata_d   = buf_wdata_q;
    page_done_d   = 1'b0;
    busy_d        = busy_q;
`ifdef EEPROM_RD_WIP_POLL_EN
    wip_d         = wip_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_pulse) begin
          cur_addr_d = start_addr;
          busy_d     = 1'b1;
          ncs_d      = 1'b0;
          state_d    = PAGE_ENTRY;
        end
      end

      ST_CS_LOW: begin
        hdr_cnt_d     = '0;
        spi_load_d    = 1'b1;
        spi_tx_data_d = hdr_byte(2'd0, cur_addr_q);
        state_d       = ST_HDR_LD;
      end

      ST_HDR_LD: state_d = ST_HDR_WT;

      ST_HDR_WT: begin
        if (spi_done) begin
          spi_load_d = 1'b1;
          if (hdr_cnt_q != 2'd3) begin
            hdr_cnt_d     = hdr_cnt_q + 2'd1;
            spi_tx_data_d = hdr_byte(hdr_cnt_q + 2'd1, cur_addr_q);
            state_d       = ST_HDR_LD;
          end else begin
            byte_cnt_d    = '0;
            spi_tx_data_d = '0;
            state_d       = ST_DAT_LD;
          end
        end
      end

      ST_DAT_LD: state_d = ST_DAT_WT;

      ST_DAT_WT: begin
        if (spi_done) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = byte_cnt_q;
          buf_wdata_d = spi_rx_data;
          if (byte_cnt_q != BYTE_LAST) begin
            byte_cnt_d    = byte_cnt_q + 8'd1;
            spi_load_d    = 1'b1;
            spi_tx_data_d = '0;
            state_d       = ST_DAT_LD;
          end else begin
            // page_done lands in the same cycle as the final buffer write
            ncs_d       = 1'b1;
            page_done_d = 1'b1;
            state_d     = ST_PAGE_END;
          end
        end
      end

      ST_PAGE_END: begin
        cur_addr_d = cur_addr_q + PAGE_INC;
        gap_cnt_d  = '0;
        state_d    = ST_CS_GAP;
      end

      ST_CS_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = ST_CHK_DONE;
        else                       gap_cnt_d = gap_cnt_q + 8'd1;
      end

      ST_CHK_DONE: begin
        if (data_done) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_BUF;
        end
      end

      ST_WAIT_BUF: begin
        if (data_done) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (buf_free) begin
          ncs_d   = 1'b0;
          state_d = PAGE_ENTRY;
        end
      end

`ifdef EEPROM_RD_WIP_POLL_EN
      // hdr_cnt doubles as the poll byte index (0 = opcode, 1 = status byte)
      ST_POLL_CS: begin
        hdr_cnt_d     = '0;
        spi_load_d    = 1'b1;
        spi_tx_data_d = RDSR_CMD;
        state_d       = ST_POLL_LD;
      end

      ST_POLL_LD: state_d = ST_POLL_WT;

      ST_POLL_WT: begin
        if (spi_done) begin
          if (hdr_cnt_q == 2'd0) begin
            hdr_cnt_d     = 2'd1;
            spi_load_d    = 1'b1;
            spi_tx_data_d = '0;
            state_d       = ST_POLL_LD;
          end else begin
            wip_d     = spi_rx_data[0];
            ncs_d     = 1'b1;
            gap_cnt_d = '0;
            state_d   = ST_POLL_GAP;
          end
        end
      end

      ST_POLL_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          ncs_d   = 1'b0;
          state_d = wip_q ? ST_POLL_CS : ST_CS_LOW;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
`endif

      default: begin
        ncs_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cur_addr_q    <= '0;
      hdr_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      ncs_q         <= 1'b1;
      spi_load_q    <= 1'b0;
      spi_tx_data_q <= '0;
      buf_we_q      <= 1'b0;
      buf_addr_q    <= '0;
      buf_wdata_q   <= '0;
      page_done_q   <= 1'b0;
      busy_q        <= 1'b0;
`ifdef EEPROM_RD_WIP_POLL_EN
      wip_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cur_addr_q    <= cur_addr_d;
      hdr_cnt_q     <= hdr_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      ncs_q         <= ncs_d;
      spi_load_q    <= spi_load_d;
      spi_tx_data_q <= spi_tx_data_d;
      buf_we_q      <= buf_we_d;
      buf_addr_q    <= buf_addr_d;
      buf_wdata_q   <= buf_wdata_d;
      page_done_q   <= page_done_d;
      busy_q        <= busy_d;
`ifdef EEPROM_RD_WIP_POLL_EN
      wip_q         <= wip_d;
`endif
    end
  end

  assign nCS         = ncs_q;
  assign spi_load    = spi_load_q;
  assign spi_tx_data = spi_tx_data_q;
  assign buf_we      = buf_we_q;
  assign buf_addr    = buf_addr_q;
  assign buf_wdata   = buf_wdata_q;
  assign page_done   = page_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_cu_eeprom_rdbuff.sv
module tb_cu_eeprom_rdbuff;

  localparam int unsigned PB  = 256;
  localparam int unsigned CSG = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_pulse;
  logic [23:0] start_addr;
  logic        data_done;
  logic        buf_free;
  logic        spi_done;
  logic [7:0]  spi_rx_data;
  logic        spi_load;
  logic [7:0]  spi_tx_data;
  logic        nCS;
  logic        buf_we;
  logic [7:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic        page_done;
  logic        busy;

  always #5 clk = ~clk;

  cu_eeprom_rdbuff #(
    .PAGE_BYTES (PB),
    .READ_CMD   (8'h03),
    .RDSR_CMD   (8'h05),
    .CS_GAP     (CSG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_pulse (start_pulse),
    .start_addr  (start_addr),
    .data_done   (data_done),
    .buf_free    (buf_free),
    .spi_done    (spi_done),
    .spi_rx_data (spi_rx_data),
    .spi_load    (spi_load),
    .spi_tx_data (spi_tx_data),
    .nCS         (nCS),
    .buf_we      (buf_we),
    .buf_addr    (buf_addr),
    .buf_wdata   (buf_wdata),
    .page_done   (page_done),
    .busy        (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // scoreboard: {buffer index, data} pushed when the SPI model returns a data byte
  logic [15:0] sb_q[$];
  logic [7:0]  hdr_q[$];
  logic        st_q[$];

  int read_txn     = 0;
  int rdsr_cnt     = 0;
  int rdsr_at_read = -1;
  int read_loads   = 0;
  int load_total   = 0;
  int we_total     = 0;
  int pg_we        = 0;
  int page_cnt     = 0;
  int min_gap      = 1000;
  int gap_run      = 0;
  logic prev_ncs   = 1'b1;

  // SPI byte-engine model: answers each spi_load two cycles later
  initial begin
    int         idx;
    logic [7:0] first, tx, resp, di;
    logic       is_data;
    idx = 0; first = 8'h00; di = 8'h00;
    spi_done = 1'b0; spi_rx_data = 8'h00;
    forever begin
      @(negedge clk);
      spi_done = 1'b0;
      if (nCS) idx = 0;
      if (spi_load) begin
        tx = spi_tx_data;
        if (idx == 0) begin
          first = tx;
          if (tx == 8'h03) begin
            read_txn++;
            rdsr_at_read = rdsr_cnt;
          end
          if (tx == 8'h05) rdsr_cnt++;
        end
        if (first == 8'h03) begin
          read_loads++;
          if (idx < 4) hdr_q.push_back(tx);
        end
        is_data = 1'b0;
        resp    = 8'hC3;
        if (first == 8'h05) begin
          if (idx == 1) begin
            resp = 8'h00;
            if (st_q.size() > 0) resp[0] = st_q.pop_front();
          end
        end else if (idx >= 4) begin
          di      = 8'(idx - 4);
          resp    = (di ^ 8'h5A) + 8'((read_txn - 1) * 7);
          is_data = 1'b1;
        end
        idx++;
        repeat (2) @(negedge clk);
        spi_rx_data = resp;
        spi_done    = 1'b1;
        if (is_data) sb_q.push_back({di, resp});
      end
    end
  end

  // output monitor
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (spi_load) begin
        load_total++;
        check_val("load_ncs_low", nCS, 1'b0);
      end
      if (buf_we) begin
        we_total++;
        pg_we++;
        if (sb_q.size() == 0) check_val("sb_underflow", 1, 0);
        else begin
          e = sb_q.pop_front();
          check_val("buf_addr", buf_addr, e[15:8]);
          check_val("buf_wdata", buf_wdata, e[7:0]);
        end
      end
      if (page_done) begin
        page_cnt++;
        check_val("page_len", pg_we, PB);
        check_val("page_done_ncs", nCS, 1'b1);
        pg_we = 0;
      end
      if (nCS) gap_run++;
      else begin
        if (prev_ncs && gap_run < min_gap) min_gap = gap_run;
        gap_run = 0;
      end
      prev_ncs = nCS;
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic do_start(input logic [23:0] a);
    start_addr  = a;
    start_pulse = 1'b1;
    tick();
    start_pulse = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (!busy) return;
    end
    check_val(tag, 1, 0);
  endtask

  task automatic check_hdr(input string tag, input logic [23:0] a);
    logic [31:0] h;
    h = {8'h03, a};
    for (int i = 0; i < 4; i++) begin
      if (hdr_q.size() == 0) check_val(tag, 32'hFFFF_FFFF, 32'(h[31 - 8*i -: 8]));
      else check_val(tag, hdr_q.pop_front(), h[31 - 8*i -: 8]);
    end
  endtask

  task automatic clear_counts();
    read_txn = 0; read_loads = 0; we_total = 0; pg_we = 0; page_cnt = 0;
    hdr_q.delete();
  endtask

  initial begin
    int lt, wt;
    bit ok;
    reset = 1'b1; start_pulse = 1'b0; start_addr = '0;
    data_done = 1'b0; buf_free = 1'b0;
    repeat (3) tick();
    // reset state
    check_val("rst_ncs", nCS, 1'b1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_load", spi_load, 1'b0);
    check_val("rst_tx", spi_tx_data, 8'h00);
    check_val("rst_we", buf_we, 1'b0);
    check_val("rst_baddr", buf_addr, 8'h00);
    check_val("rst_bdata", buf_wdata, 8'h00);
    check_val("rst_pdone", page_done, 1'b0);
    reset = 1'b0;
    repeat (3) tick();

    // stray spi_done in IDLE
    lt = load_total; wt = we_total;
    spi_rx_data = 8'hEE; spi_done = 1'b1;
    tick();
    repeat (5) tick();
    check_val("stray_busy", busy, 1'b0);
    check_val("stray_ncs", nCS, 1'b1);
    check_val("stray_loads", load_total, lt);
    check_val("stray_we", we_total, wt);

    // single page, second start while busy ignored
    clear_counts();
    data_done = 1'b1;
    do_start(24'h012300);
    check_val("busy_after_start", busy, 1'b1);
    do_start(24'hABCDEF);
    wait_idle("timeout_single", 4000);
    check_hdr("hdr_single", 24'h012300);
    check_val("single_reads", read_txn, 1);
    check_val("single_loads", read_loads, 4 + PB);
    check_val("single_we", we_total, PB);
    check_val("single_pages", page_cnt, 1);
    check_val("single_sb_empty", sb_q.size(), 0);
    repeat (5) tick();
    check_val("single_still_idle", busy, 1'b0);

    // two pages, buf_free held off for 50 cycles
    clear_counts();
    data_done = 1'b0; buf_free = 1'b0;
    do_start(24'h012300);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      tick();
      ok = (page_cnt >= 1);
    end
    check_val("bf_page1_seen", ok, 1'b1);
    repeat (50) tick();
    check_val("bf_held_reads", read_txn, 1);
    check_val("bf_held_ncs", nCS, 1'b1);
    check_val("bf_held_busy", busy, 1'b1);
    buf_free = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      ok = !nCS;
    end
    check_val("bf_ncs_fall", ok, 1'b1);
    buf_free = 1'b0; data_done = 1'b1;
    wait_idle("timeout_bf", 8000);
    check_hdr("hdr_bf_p1", 24'h012300);
    check_hdr("hdr_bf_p2", 24'h012400);
    check_val("bf_pages", page_cnt, 2);
    check_val("bf_we", we_total, 2 * PB);

    // address wrap
    clear_counts();
    data_done = 1'b0; buf_free = 1'b1;
    do_start(24'hFFFF00);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      tick();
      ok = (read_txn >= 2);
    end
    check_val("wrap_second_read", ok, 1'b1);
    data_done = 1'b1; buf_free = 1'b0;
    wait_idle("timeout_wrap", 4000);
    check_hdr("hdr_wrap_p1", 24'hFFFF00);
    check_hdr("hdr_wrap_p2", 24'h000000);
    check_val("wrap_pages", page_cnt, 2);

    // reset in the middle of a page
    clear_counts();
    data_done = 1'b1;
    do_start(24'h000100);
    ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      tick();
      ok = (pg_we >= 100);
    end
    check_val("mid_reached_100", ok, 1'b1);
    reset = 1'b1;
    #1;
    check_val("mid_rst_ncs", nCS, 1'b1);
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_we", buf_we, 1'b0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (12) tick();
    sb_q.delete();
    clear_counts();
    do_start(24'h000100);
    wait_idle("timeout_mid", 4000);
    check_hdr("hdr_mid", 24'h000100);
    check_val("mid_we", we_total, PB);
    check_val("mid_pages", page_cnt, 1);

`ifdef EEPROM_RD_WIP_POLL_EN
    // WIP poll: busy, busy, ready
    clear_counts();
    rdsr_cnt = 0;
    st_q.push_back(1'b1); st_q.push_back(1'b1); st_q.push_back(1'b0);
    data_done = 1'b1;
    do_start(24'h000200);
    wait_idle("timeout_poll", 4000);
    check_val("poll_rdsr_before_read", rdsr_at_read, 3);
    check_val("poll_status_used", st_q.size(), 0);
    check_hdr("hdr_poll", 24'h000200);
    check_val("poll_we", we_total, PB);
`else
    check_val("no_rdsr_sent", rdsr_cnt, 0);
`endif

    check_val("min_ncs_gap_ok", 32'(min_gap >= int'(CSG)), 1);
    check_val("final_sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
